// File: rtl/dc_katsayi_cozucu.sv
// JPEG DC coefficient rebuild: SSSS category plus serial amplitude bits, added to the running predictor.
// Result one edge after the last bit (kat=0: after the category); accepts a category only when kat_hazir_o, bits only when bit_hazir_o.
module dc_katsayi_cozucu #(
  parameter int KAT_W     = 4,
  parameter int KATSAYI_W = 12,
  parameter int MAKS_KAT  = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 kat_gecerli_i,
  input  logic [KAT_W-1:0]     kat_i,
  output logic                 kat_hazir_o,
  input  logic                 bit_gecerli_i,
  input  logic                 bit_i,
  output logic                 bit_hazir_o,
  input  logic                 ongorucu_sifirla_i,
  output logic [KATSAYI_W-1:0] dc_o,
  output logic                 dc_gecerli_o,
  output logic                 hata_o
);

  typedef enum logic [1:0] {
    BOS     = 2'd0,
    BIT_AL  = 2'd1,
    HESAPLA = 2'd2
  } durum_t;

  durum_t               r_durum;
  logic [KATSAYI_W-1:0] r_kaydirma;
  logic [KAT_W-1:0]     r_sayac;
  logic [KAT_W-1:0]     r_kat;
  logic [KATSAYI_W-1:0] r_ongorucu;
  logic [KATSAYI_W-1:0] r_dc;
  logic                 r_dc_gecerli;
  logic                 r_hata;

  logic [KATSAYI_W-1:0] w_maske;
  logic [KATSAYI_W-1:0] w_isaret_maske;
  logic                 w_pozitif;
  logic [KATSAYI_W-1:0] w_fark;
  logic [KATSAYI_W-1:0] w_taban;
  logic [KATSAYI_W-1:0] w_sonuc;
  logic                 w_bit_kabul;

  // w_maske = 2^s-1; its top set bit selects the amplitude MSB (bit s-1), empty for s=0.
  assign w_maske        = (KATSAYI_W'(1) << r_kat) - KATSAYI_W'(1);
  assign w_isaret_maske = w_maske ^ (w_maske >> 1);
  assign w_pozitif      = |(r_kaydirma & w_isaret_maske);
  assign w_fark         = (r_kat == '0) ? '0 :
                          (w_pozitif ? r_kaydirma : r_kaydirma - w_maske);
  assign w_taban        = ongorucu_sifirla_i ? '0 : r_ongorucu;
  assign w_sonuc        = w_taban + w_fark;

  assign w_bit_kabul = bit_gecerli_i && (r_durum == BIT_AL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_durum      <= BOS;
      r_kaydirma   <= '0;
      r_sayac      <= '0;
      r_kat        <= '0;
      r_ongorucu   <= '0;
      r_dc         <= '0;
      r_dc_gecerli <= 1'b0;
      r_hata       <= 1'b0;
    end else begin
      r_dc_gecerli <= 1'b0;

      if (r_durum == HESAPLA) begin
        r_ongorucu <= w_sonuc;
      end else if (ongorucu_sifirla_i) begin
        r_ongorucu <= '0;
      end

      case (r_durum)
        BOS: begin
          if (kat_gecerli_i) begin
            if (kat_i > KAT_W'(MAKS_KAT)) begin
              r_hata <= 1'b1;
            end else begin
              r_kat      <= kat_i;
              r_sayac    <= kat_i;
              r_kaydirma <= '0;
              r_durum    <= (kat_i == '0) ? HESAPLA : BIT_AL;
            end
          end
        end
        BIT_AL: begin
          if (w_bit_kabul) begin
            r_kaydirma <= {r_kaydirma[KATSAYI_W-2:0], bit_i};
            r_sayac    <= r_sayac - KAT_W'(1);
            if (r_sayac == KAT_W'(1)) begin
              r_durum <= HESAPLA;
            end
          end
        end
        HESAPLA: begin
          r_dc         <= w_sonuc;
          r_dc_gecerli <= 1'b1;
          r_durum      <= BOS;
        end
        default: r_durum <= BOS;
      endcase
    end
  end

  assign kat_hazir_o  = (r_durum == BOS);
  assign bit_hazir_o  = (r_durum == BIT_AL);
  assign dc_o         = r_dc;
  assign dc_gecerli_o = r_dc_gecerli;
  assign hata_o       = r_hata;

endmodule

// File: tb/tb_dc_katsayi_cozucu.sv
// Directed bench for dc_katsayi_cozucu with hand-computed DC results.
module tb_dc_katsayi_cozucu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        kat_gecerli_i;
  logic [3:0]  kat_i;
  logic        kat_hazir_o;
  logic        bit_gecerli_i;
  logic        bit_i;
  logic        bit_hazir_o;
  logic        ongorucu_sifirla_i;
  logic [11:0] dc_o;
  logic        dc_gecerli_o;
  logic        hata_o;

  int n_kontrol = 0;
  int n_hata    = 0;

  dc_katsayi_cozucu u_dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .kat_gecerli_i      (kat_gecerli_i),
    .kat_i              (kat_i),
    .kat_hazir_o        (kat_hazir_o),
    .bit_gecerli_i      (bit_gecerli_i),
    .bit_i              (bit_i),
    .bit_hazir_o        (bit_hazir_o),
    .ongorucu_sifirla_i (ongorucu_sifirla_i),
    .dc_o               (dc_o),
    .dc_gecerli_o       (dc_gecerli_o),
    .hata_o             (hata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    n_kontrol++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", etiket, gozlenen, beklenen);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic adim();
    @(posedge clk_i);
    #1;
  endtask

  task automatic kat_gonder(input logic [3:0] k);
    int n = 0;
    while (!kat_hazir_o && n < 20) begin
      adim();
      n++;
    end
    kontrol("kat_hazir", kat_hazir_o, 1);
    kat_gecerli_i = 1'b1;
    kat_i         = k;
    adim();
    kat_gecerli_i = 1'b0;
    kat_i         = '0;
  endtask

  task automatic bit_gonder(input logic b, input int bosluk);
    for (int i = 0; i < bosluk; i++) adim();
    kontrol("bit_hazir", bit_hazir_o, 1);
    bit_gecerli_i = 1'b1;
    bit_i         = b;
    adim();
    bit_gecerli_i = 1'b0;
    bit_i         = 1'b0;
  endtask

  task automatic bitler_gonder(input logic [10:0] deger, input int s, input int bosluk);
    for (int i = s - 1; i >= 0; i--) bit_gonder(deger[i], bosluk);
  endtask

  task automatic sonuc_bekle(input string etiket, input logic [11:0] beklenen, input logic sifirla);
    kontrol({etiket, "_erken"}, dc_gecerli_o, 0);
    ongorucu_sifirla_i = sifirla;
    adim();
    ongorucu_sifirla_i = 1'b0;
    kontrol({etiket, "_vld"}, dc_gecerli_o, 1);
    kontrol({etiket, "_dc"}, dc_o, beklenen);
    adim();
    kontrol({etiket, "_vld_dus"}, dc_gecerli_o, 0);
    kontrol({etiket, "_dc_tut"}, dc_o, beklenen);
  endtask

  task automatic ongorucu_temizle();
    ongorucu_sifirla_i = 1'b1;
    adim();
    ongorucu_sifirla_i = 1'b0;
  endtask

  initial begin
    rst_ni             = 1'b0;
    kat_gecerli_i      = 1'b0;
    kat_i              = '0;
    bit_gecerli_i      = 1'b0;
    bit_i              = 1'b0;
    ongorucu_sifirla_i = 1'b0;
    repeat (3) adim();
    kontrol("rst_dc", dc_o, 0);
    kontrol("rst_vld", dc_gecerli_o, 0);
    kontrol("rst_hata", hata_o, 0);
    kontrol("rst_kat_hazir", kat_hazir_o, 1);
    kontrol("rst_bit_hazir", bit_hazir_o, 0);
    rst_ni = 1'b1;
    adim();

    kat_gonder(4'd3);
    bitler_gonder(11'b101, 3, 0);
    sonuc_bekle("k3_p5", 12'd5, 1'b0);
    kat_gonder(4'd3);
    bitler_gonder(11'b010, 3, 0);
    sonuc_bekle("k3_m5", 12'd0, 1'b0);

    kat_gonder(4'd0);
    sonuc_bekle("k0", 12'd0, 1'b0);
    kat_gonder(4'd11);
    bitler_gonder(11'd0, 11, 0);
    sonuc_bekle("k11_m2047", 12'h801, 1'b0);

    ongorucu_temizle();
    kat_gonder(4'd11);
    bitler_gonder(11'h7FF, 11, 0);
    sonuc_bekle("k11_p2047", 12'h7FF, 1'b0);
    kat_gonder(4'd1);
    bitler_gonder(11'b1, 1, 0);
    sonuc_bekle("sarma", 12'h800, 1'b0);

    kat_gonder(4'd12);
    kontrol("k12_hata", hata_o, 1);
    kontrol("k12_hazir", kat_hazir_o, 1);
    for (int i = 0; i < 3; i++) begin
      kontrol("k12_vld_yok", dc_gecerli_o, 0);
      adim();
    end
    kontrol("k12_hata_kalici", hata_o, 1);
    ongorucu_temizle();
    kat_gonder(4'd2);
    bitler_gonder(11'b11, 2, 0);
    sonuc_bekle("hata_sonra_k2", 12'd3, 1'b0);
    kontrol("hata_hala", hata_o, 1);

    for (int tur = 0; tur < 2; tur++) begin
      ongorucu_temizle();
      kat_gonder(4'd7);
      bitler_gonder(11'd100, 7, 0);
      sonuc_bekle("p100", 12'd100, 1'b0);
      kat_gonder(4'd4);
      kat_gecerli_i = 1'b1;
      kat_i         = 4'd2;
      adim();
      kat_gecerli_i = 1'b0;
      kat_i         = '0;
      kontrol("fazla_kat_bit_hazir", bit_hazir_o, 1);
      kontrol("fazla_kat_kat_hazir", kat_hazir_o, 0);
      bitler_gonder(11'b1000, 4, 3);
      if (tur == 0) sonuc_bekle("bosluklu_108", 12'd108, 1'b0);
      else          sonuc_bekle("bosluklu_sifirla", 12'd8, 1'b1);
    end
    kat_gonder(4'd1);
    bitler_gonder(11'b1, 1, 0);
    sonuc_bekle("sifirla_sonrasi", 12'd9, 1'b0);

    kat_gonder(4'd5);
    bitler_gonder(11'b11, 2, 0);
    #2 rst_ni = 1'b0;
    #1;
    kontrol("ara_rst_dc", dc_o, 0);
    kontrol("ara_rst_hata", hata_o, 0);
    kontrol("ara_rst_kat_hazir", kat_hazir_o, 1);
    kontrol("ara_rst_bit_hazir", bit_hazir_o, 0);
    adim();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      adim();
      kontrol("ara_rst_vld_yok", dc_gecerli_o, 0);
    end
    kat_gonder(4'd1);
    bitler_gonder(11'b0, 1, 0);
    sonuc_bekle("k1_m1", 12'hFFF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_kontrol, n_hata);
    $finish;
  end

endmodule

// File: doc/dc_katsayi_cozucu.md
Name: dc_katsayi_cozucu

Overview:
- Downstream stage of the DC Huffman category decoder in the JPEG entropy-decode path.
- Takes the decoded DC category (SSSS, 0..11), shifts in SSSS serial amplitude bits, and reconstructs the signed DC difference.
- Adds the difference to the running DC predictor and emits the absolute DC coefficient, which feeds the dequantiser / IDCT block assembler.

Parameters:
- KAT_W, 4, width of the category input (max category 11).
- KATSAYI_W, 12, width of the signed DC coefficient and predictor (two's complement).
- MAKS_KAT, 11, highest legal category; any value above it is an error.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- kat_gecerli_i  input  1  category valid strobe; sampled only in BOS.
- kat_i  input  KAT_W  DC category SSSS.
- kat_hazir_o  output  1  high when state is BOS (ready for a category).
- bit_gecerli_i  input  1  amplitude bit valid.
- bit_i  input  1  amplitude bit, MSB first.
- bit_hazir_o  output  1  high in BIT_AL; a bit is consumed when bit_gecerli_i && bit_hazir_o.
- ongorucu_sifirla_i  input  1  clears the DC predictor (new scan / restart marker).
- dc_o  output  KATSAYI_W  signed DC coefficient, held until the next result.
- dc_gecerli_o  output  1  one-cycle pulse; dc_o is new.
- hata_o  output  1  sticky flag for an illegal category; cleared only by reset.

Behaviour:
- Reset (rst_ni=0, asynchronous) sets: state=BOS, predictor=0, shift register=0, counter=0, dc_o=0, dc_gecerli_o=0, hata_o=0.
- FSM states: BOS, BIT_AL, HESAPLA.
- BOS, on kat_gecerli_i:
  - kat_i=0 -> diff=0, go to HESAPLA.
  - kat_i in 1..MAKS_KAT -> load counter=kat_i, clear shift register, go to BIT_AL.
  - kat_i>MAKS_KAT -> set hata_o, stay in BOS, no output pulse.
- BIT_AL:
  - Each accepted bit: shift register = {shift register, bit_i}; counter decrements.
  - The accept that brings counter to 0 moves the FSM to HESAPLA.
  - No timeout. Gaps in bit_gecerli_i are allowed.
- HESAPLA lasts exactly one cycle.
  - Let raw = shifted value and s = category.
  - If s=0: diff=0.
  - Else if the MSB of raw (bit s-1) is 1: diff=+raw.
  - Else: diff=raw-(2^s-1), which is negative.
  - The diff range is +/-2047, sign-extended to KATSAYI_W.
  - Result = predictor + diff, truncated to KATSAYI_W (modulo 2^KATSAYI_W, wraps with no saturation).
  - At the HESAPLA edge, predictor, dc_o and dc_gecerli_o are all registered together, then the FSM returns to BOS.
- Latency: dc_gecerli_o goes high on the edge after the last amplitude bit is accepted (kat=0: the edge after kat_gecerli_i). Minimum category-to-category spacing is 2 cycles for kat=0 and s+2 cycles otherwise.
- kat_gecerli_i is ignored outside BOS. bit_gecerli_i is ignored outside BIT_AL.
- ongorucu_sifirla_i is honoured in any state and zeroes the predictor at the edge.
  - Asserted on the HESAPLA edge: the predictor is taken as 0, so dc_o = diff and the stored predictor = diff.
- hata_o does not block later legal categories.
- Reset mid-operation discards the partial shift register and any pending result. No dc_gecerli_o pulse follows.

Test Plan:
- Reset, then kat=3 with bits 1,0,1 -> diff=+5; dc_o=5, one dc_gecerli_o pulse 1 cycle after the third bit. Then kat=3 with bits 0,1,0 -> raw 2, diff=-5; dc_o=0.
- Predictor=0, kat=0 -> dc_o=0 one cycle after kat_gecerli_i. Then kat=11 with eleven 0 bits -> diff=-2047; dc_o=0x801.
- Predictor=2047 (kat=11, all ones), then kat=1 with bit 1 -> wraps; dc_o=0x800 (-2048).
- kat=12 -> hata_o=1 and stays high, no dc_gecerli_o, kat_hazir_o stays 1. A following kat=2 with bits 1,1 -> dc_o=3, hata_o remains 1.
- Predictor=100, kat=4 with bits sent with 3-cycle gaps and an extra kat_gecerli_i pulse in BIT_AL -> extra strobe ignored; bits 1,0,0,0 -> diff=8, dc_o=108. Same case again with ongorucu_sifirla_i on the HESAPLA edge -> dc_o=8.
- rst_ni low after 2 of 5 bits of kat=5 -> all outputs 0 immediately, state BOS, no pulse. Then kat=1 with bit 0 -> diff=-1; dc_o=0xFFF.
